jelly_capacity_timeout_multi: RTL and testbench
===============================================

Name: jelly_capacity_timeout_multi

Overview:
Multi-channel successor to the single-channel capacity/timeout issuer. It keeps N independent credit accumulators, each with its own age timer. A channel issues in chunks of up to max_issue_size, or issues its remainder once its timer reaches timeout. One registered issue port is shared by all channels under round-robin arbitration and carries a channel id. It sits between per-stream request producers (e.g. DMA write-combiners) and a single downstream command issuer.

Parameters:
N, 4, number of channels
ID_WIDTH, 2, width of m_issue_id; must satisfy 2^ID_WIDTH >= N
TIMER_WIDTH, 8, per-channel timer width
CAPACITY_WIDTH, 32, per-channel accumulator width
REQUEST_WIDTH, CAPACITY_WIDTH, request size width
ISSUE_WIDTH, 8, issue size width
REQUEST_SIZE_OFFSET, 1'b0, added to every s_request_size
ISSUE_SIZE_OFFSET, 1'b1, m_issue_size encodes (issued amount - offset)
INIT_REQUEST, {N*CAPACITY_WIDTH{1'b0}}, per-channel accumulator reset value

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cke  in  1  clock enable; all state frozen while low
max_issue_size  in  ISSUE_WIDTH  maximum chunk, encoded with ISSUE_SIZE_OFFSET
timeout  in  TIMER_WIDTH  age threshold, shared by all channels
queued_request  out  N*CAPACITY_WIDTH  per-channel accumulator
current_timer  out  N*TIMER_WIDTH  per-channel timer
s_request_size  in  N*REQUEST_WIDTH  per-channel request amount
s_request_valid  in  N  per-channel request strobe; always accepted, no ready
m_issue_id  out  ID_WIDTH  granted channel
m_issue_size  out  ISSUE_WIDTH  issued amount - ISSUE_SIZE_OFFSET
m_issue_valid  out  1  issue valid
m_issue_ready  in  1  issue ready

Behaviour:
- Reset (async, aresetn=0): queued = INIT_REQUEST; timers 0; m_issue_valid 0; m_issue_id 0; m_issue_size 0; round-robin pointer = N-1, so channel 0 wins first.
- Let MAX = max_issue_size + ISSUE_SIZE_OFFSET, computed in CAPACITY_WIDTH.
- Per-channel eligibility, from registered state only:
  - full = queued >= MAX
  - aged = (queued != 0) and (timer >= timeout)
  - eligible = full or aged
- Load condition: load = (!m_issue_valid or m_issue_ready) and any eligible.
- On load:
  - Grant the first eligible channel after the pointer (wrapping); the pointer becomes the granted channel.
  - amount = min(queued[g], MAX); m_issue_size <= amount - ISSUE_SIZE_OFFSET; m_issue_id <= g; m_issue_valid <= 1.
- If m_issue_ready and no channel is eligible: m_issue_valid <= 0.
- While m_issue_valid and !m_issue_ready: id, size and valid hold stable and no new grant is made.
- Accumulator update in the same cycle: queued_next = queued + (s_request_valid ? s_request_size + REQUEST_SIZE_OFFSET : 0) - (granted ? amount : 0). Simultaneous add and subtract are both applied.
- Overflow wraps. Producers are responsible for staying within CAPACITY_WIDTH.
- Timer:
  - Cleared when the channel is granted or when queued_next == 0.
  - Otherwise increments each cke cycle while queued != 0, saturating at all-ones.
- Latency: a request strobed at edge t is visible in queued after t. The earliest m_issue_valid is after edge t+1.
- timeout = 0: a channel is eligible as soon as queued != 0.
- Zero-amount issues never occur.
- Conservation per channel: sum of issued amounts = INIT + sum of requests - final queued.

Test Plan:
- Aging: N=4, max_issue_size=0x7f, timeout=0x0f; ch0 request 300, ready=1 -> id0 size 0x7f, then id0 size 0x7f, then 44 cycles later... precisely: after the two full chunks, id0 size 0x2b is issued the cycle after timer reaches 15.
- Timeout only: ch1 request 10, timeout=0x0f -> current_timer[1] counts 0..15; then id1 size 9; queued[1]=0 and timer 0 afterwards.
- Round-robin: all four channels request 200 in the same cycle, ready=1 -> grant order 0,1,2,3 with size 0x7f each; then, after timeout, 0,1,2,3 with size 71.
- Backpressure: ready=0 for 20 cycles while valid -> id and size constant, exactly one deduction taken; ch2 requests 5 during the stall -> queued[2] grows by 5.
- Reset mid-operation: aresetn low while valid=1 -> valid drops without waiting for a clock edge; queued=INIT_REQUEST, timers 0; after release, channel 0 is granted first.
- Random soak: 2000 cycles of random sizes (&0xff), 10% valid per channel, random ready, then drain 3000 cycles -> per-channel request sum == issue sum, all queued 0.

Source files
------------

// File: rtl/jelly_capacity_timeout_multi.sv
// Multi-channel credit accumulator with per-channel age timers; issues chunks up to a maximum
// size, or the remainder on timeout, through one round-robin arbitrated issue port.
module jelly_capacity_timeout_multi #(
    parameter int unsigned                  N                   = 4,
    parameter int unsigned                  ID_WIDTH            = 2,
    parameter int unsigned                  TIMER_WIDTH         = 8,
    parameter int unsigned                  CAPACITY_WIDTH      = 32,
    parameter int unsigned                  REQUEST_WIDTH       = CAPACITY_WIDTH,
    parameter int unsigned                  ISSUE_WIDTH         = 8,
    parameter logic [REQUEST_WIDTH-1:0]     REQUEST_SIZE_OFFSET = '0,
    parameter logic [ISSUE_WIDTH-1:0]       ISSUE_SIZE_OFFSET   = ISSUE_WIDTH'(1),
    parameter logic [N*CAPACITY_WIDTH-1:0]  INIT_REQUEST        = '0
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cke,
    input  logic [ISSUE_WIDTH-1:0]        max_issue_size,
    input  logic [TIMER_WIDTH-1:0]        timeout,
    output logic [N*CAPACITY_WIDTH-1:0]   queued_request,
    output logic [N*TIMER_WIDTH-1:0]      current_timer,
    input  logic [N*REQUEST_WIDTH-1:0]    s_request_size,
    input  logic [N-1:0]                  s_request_valid,
    output logic [ID_WIDTH-1:0]           m_issue_id,
    output logic [ISSUE_WIDTH-1:0]        m_issue_size,
    output logic                          m_issue_valid,
    input  logic                          m_issue_ready
);

    logic [CAPACITY_WIDTH-1:0] queued_q [N];
    logic [CAPACITY_WIDTH-1:0] queued_d [N];
    logic [TIMER_WIDTH-1:0]    timer_q  [N];
    logic [TIMER_WIDTH-1:0]    timer_d  [N];
    logic [CAPACITY_WIDTH-1:0] add_amt  [N];

    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [ISSUE_WIDTH-1:0]    size_q, size_d;
    logic                      valid_q, valid_d;
    logic [ID_WIDTH-1:0]       rr_q, rr_d;

    logic [CAPACITY_WIDTH-1:0] max_size;
    logic [CAPACITY_WIDTH-1:0] amount;
    logic [N-1:0]              eligible;
    logic [N-1:0]              granted;
    logic [ID_WIDTH-1:0]       grant_idx;
    logic                      found;
    logic                      load;
    int                        idx;

    always_comb begin
        max_size  = CAPACITY_WIDTH'(max_issue_size) + CAPACITY_WIDTH'(ISSUE_SIZE_OFFSET);
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;

        for (int i = 0; i < int'(N); i++) begin
            eligible[i] = (queued_q[i] >= max_size) ||
                          ((queued_q[i] != '0) && (timer_q[i] >= timeout));
        end

        // Search starts just after the last grant so every channel gets a turn.
        for (int k = 1; k <= int'(N); k++) begin
            idx = (int'(rr_q) + k) % int'(N);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end

        load   = (!valid_q || m_issue_ready) && (|eligible);
        amount = (queued_q[grant_idx] < max_size) ? queued_q[grant_idx] : max_size;

        valid_d = valid_q;
        id_d    = id_q;
        size_d  = size_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = 1'b1;
            id_d    = grant_idx;
            size_d  = ISSUE_WIDTH'(amount - CAPACITY_WIDTH'(ISSUE_SIZE_OFFSET));
            rr_d    = grant_idx;
        end else if (m_issue_ready) begin
            valid_d = 1'b0;
        end

        for (int i = 0; i < int'(N); i++) begin
            add_amt[i]  = s_request_valid[i]
                        ? CAPACITY_WIDTH'(s_request_size[i*REQUEST_WIDTH +: REQUEST_WIDTH])
                          + CAPACITY_WIDTH'(REQUEST_SIZE_OFFSET)
                        : '0;
            granted[i]  = load && (grant_idx == ID_WIDTH'(i));
            queued_d[i] = queued_q[i] + add_amt[i] - (granted[i] ? amount : '0);
            if (granted[i] || (queued_d[i] == '0)) begin
                timer_d[i] = '0;
            end else if ((queued_q[i] != '0) && (timer_q[i] != '1)) begin
                timer_d[i] = timer_q[i] + TIMER_WIDTH'(1);
            end else begin
                timer_d[i] = timer_q[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(N); i++) begin
                queued_q[i] <= INIT_REQUEST[i*CAPACITY_WIDTH +: CAPACITY_WIDTH];
                timer_q[i]  <= '0;
            end
            id_q    <= '0;
            size_q  <= '0;
            valid_q <= 1'b0;
            rr_q    <= ID_WIDTH'(N - 1);
        end else if (cke) begin
            for (int i = 0; i < int'(N); i++) begin
                queued_q[i] <= queued_d[i];
                timer_q[i]  <= timer_d[i];
            end
            id_q    <= id_d;
            size_q  <= size_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_out
        assign queued_request[gi*CAPACITY_WIDTH +: CAPACITY_WIDTH] = queued_q[gi];
        assign current_timer[gi*TIMER_WIDTH +: TIMER_WIDTH]        = timer_q[gi];
    end

    assign m_issue_id    = id_q;
    assign m_issue_size  = size_q;
    assign m_issue_valid = valid_q;

endmodule

// File: tb/tb_jelly_capacity_timeout_multi.sv
// Directed and table-driven bench for jelly_capacity_timeout_multi, with a conservation soak.
module tb_jelly_capacity_timeout_multi;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int TW = 8;

    logic            aclk;
    logic            aresetn;
    logic            cke;
    logic [7:0]      max_issue_size;
    logic [TW-1:0]   timeout;
    logic [N*CW-1:0] queued_request;
    logic [N*TW-1:0] current_timer;
    logic [N*CW-1:0] s_request_size;
    logic [N-1:0]    s_request_valid;
    logic [1:0]      m_issue_id;
    logic [7:0]      m_issue_size;
    logic            m_issue_valid;
    logic            m_issue_ready;

    int total;
    int bad;
    logic      mon_en;
    longint    req_sum [N];
    longint    iss_sum [N];

    typedef struct {
        logic [3:0] req_v;
        logic       ready;
        logic       exp_v;
        logic [1:0] exp_id;
        logic [7:0] exp_size;
    } vec_t;
    vec_t vecs [22];

    jelly_capacity_timeout_multi dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cke             (cke),
        .max_issue_size  (max_issue_size),
        .timeout         (timeout),
        .queued_request  (queued_request),
        .current_timer   (current_timer),
        .s_request_size  (s_request_size),
        .s_request_valid (s_request_valid),
        .m_issue_id      (m_issue_id),
        .m_issue_size    (m_issue_size),
        .m_issue_valid   (m_issue_valid),
        .m_issue_ready   (m_issue_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Issue scoreboard: a handshake at an enabled edge moves (size + 1) out of a channel.
    always @(posedge aclk) begin
        if (mon_en && aresetn && cke && m_issue_valid && m_issue_ready) begin
            iss_sum[m_issue_id] <= iss_sum[m_issue_id] + longint'(m_issue_size) + 1;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] q_of(input int ch);
        return queued_request[ch*CW +: CW];
    endfunction

    function automatic logic [TW-1:0] t_of(input int ch);
        return current_timer[ch*TW +: TW];
    endfunction

    task automatic set_req(input int ch, input logic [CW-1:0] sz);
        s_request_valid[ch]          = 1'b1;
        s_request_size[ch*CW +: CW]  = sz;
    endtask

    task automatic clr_req();
        s_request_valid = '0;
        s_request_size  = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clr_req();
        #12;
        tick();
        aresetn = 1'b1;
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, "_valid"}, 64'(m_issue_valid), 64'd0);
        chk({tag, "_id"},    64'(m_issue_id),    64'd0);
        chk({tag, "_size"},  64'(m_issue_size),  64'd0);
        for (int c = 0; c < N; c++) begin
            chk({tag, "_queued"}, 64'(q_of(c)), 64'd0);
            chk({tag, "_timer"},  64'(t_of(c)), 64'd0);
        end
    endtask

    initial begin
        logic       pv, pr;
        logic [1:0] pid;
        logic [7:0] psize;
        logic [CW-1:0] rsz;

        total          = 0;
        bad            = 0;
        mon_en         = 1'b0;
        cke            = 1'b1;
        max_issue_size = 8'h7f;
        timeout        = 8'h0f;
        m_issue_ready  = 1'b1;
        aresetn        = 1'b1;
        clr_req();
        for (int c = 0; c < N; c++) begin
            req_sum[c] = 0;
            iss_sum[c] = 0;
        end

        for (int i = 0; i < 22; i++) vecs[i] = '{4'h0, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[0].req_v = 4'hf;
        for (int k = 0; k < 4; k++) begin
            vecs[1 + k]  = '{4'h0, 1'b1, 1'b1, 2'(k), 8'h7f};
            vecs[17 + k] = '{4'h0, 1'b1, 1'b1, 2'(k), 8'd71};
        end

        #3;
        aresetn = 1'b0;
        #1;
        chk_idle_state("reset");
        #8;
        tick();
        aresetn = 1'b1;

        // Aging: 300 = 128 + 128 + 44, remainder leaves once its timer reaches 15.
        set_req(0, 300);
        tick();
        clr_req();
        chk("age_q_init", 64'(q_of(0)), 64'd300);
        chk("age_v_init", 64'(m_issue_valid), 64'd0);
        tick();
        chk("age_c1", {m_issue_valid, 6'd0, m_issue_id, m_issue_size}, {1'b1, 6'd0, 2'd0, 8'h7f});
        chk("age_q1", 64'(q_of(0)), 64'd172);
        tick();
        chk("age_c2", {m_issue_valid, 6'd0, m_issue_id, m_issue_size}, {1'b1, 6'd0, 2'd0, 8'h7f});
        chk("age_q2", 64'(q_of(0)), 64'd44);
        for (int k = 3; k <= 17; k++) begin
            tick();
            if (k == 3 || k == 17) chk("age_wait_v", 64'(m_issue_valid), 64'd0);
        end
        chk("age_t15", 64'(t_of(0)), 64'd15);
        tick();
        chk("age_c3", {m_issue_valid, 6'd0, m_issue_id, m_issue_size}, {1'b1, 6'd0, 2'd0, 8'h2b});
        chk("age_q3", 64'(q_of(0)), 64'd0);

        // Timeout only, with a cke freeze partway through the count.
        do_reset();
        set_req(1, 10);
        tick();
        clr_req();
        chk("to_t0", 64'(t_of(1)), 64'd0);
        chk("to_q0", 64'(q_of(1)), 64'd10);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("to_count", 64'(t_of(1)), 64'(k));
            if (k == 5) begin
                cke = 1'b0;
                set_req(1, 7);
                tick();
                tick();
                tick();
                clr_req();
                cke = 1'b1;
                chk("cke_t_frozen", 64'(t_of(1)), 64'd5);
                chk("cke_q_frozen", 64'(q_of(1)), 64'd10);
            end
        end
        chk("to_v15", 64'(m_issue_valid), 64'd0);
        tick();
        chk("to_issue", {m_issue_valid, 6'd0, m_issue_id, m_issue_size}, {1'b1, 6'd0, 2'd1, 8'd9});
        chk("to_q_after", 64'(q_of(1)), 64'd0);
        chk("to_t_after", 64'(t_of(1)), 64'd0);

        // Backpressure: one grant held for 20 cycles, other channels keep accumulating.
        do_reset();
        m_issue_ready = 1'b0;
        set_req(0, 300);
        tick();
        clr_req();
        tick();
        chk("bp_first", {m_issue_valid, 6'd0, m_issue_id, m_issue_size}, {1'b1, 6'd0, 2'd0, 8'h7f});
        for (int k = 0; k < 20; k++) begin
            if (k == 5) set_req(2, 5);
            tick();
            clr_req();
            chk("bp_hold", {m_issue_valid, 6'd0, m_issue_id, m_issue_size},
                {1'b1, 6'd0, 2'd0, 8'h7f});
            chk("bp_q0", 64'(q_of(0)), 64'd172);
        end
        chk("bp_q2", 64'(q_of(2)), 64'd5);

        // Asynchronous reset while valid is high.
        #2;
        aresetn = 1'b0;
        #1;
        chk_idle_state("async_rst");
        #10;
        tick();
        aresetn = 1'b1;
        m_issue_ready = 1'b1;

        // Round-robin table: all channels ask for 200 in the same cycle.
        for (int i = 0; i < 22; i++) begin
            for (int c = 0; c < N; c++) begin
                if (vecs[i].req_v[c]) set_req(c, 200);
            end
            m_issue_ready = vecs[i].ready;
            tick();
            clr_req();
            chk("rr_valid", 64'(m_issue_valid), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk("rr_id",   64'(m_issue_id),   64'(vecs[i].exp_id));
                chk("rr_size", 64'(m_issue_size), 64'(vecs[i].exp_size));
            end
        end
        for (int c = 0; c < N; c++) begin
            chk("rr_q_end", 64'(q_of(c)), 64'd0);
            chk("rr_t_end", 64'(t_of(c)), 64'd0);
        end

        // Random soak, then drain; every channel must conserve its credit.
        do_reset();
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc < 2000) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(9) == 0) begin
                        rsz = CW'($urandom & 32'hff);
                        set_req(c, rsz);
                        req_sum[c] += longint'(rsz);
                    end
                end
                m_issue_ready = 1'($urandom_range(1));
            end else begin
                m_issue_ready = 1'b1;
            end
            pv    = m_issue_valid;
            pr    = m_issue_ready;
            pid   = m_issue_id;
            psize = m_issue_size;
            tick();
            clr_req();
            if (pv && !pr) begin
                chk("soak_stall", {m_issue_valid, 6'd0, m_issue_id, m_issue_size},
                    {1'b1, 6'd0, pid, psize});
            end
        end
        mon_en = 1'b0;
        for (int c = 0; c < N; c++) begin
            chk("soak_conserve", 64'(iss_sum[c]), 64'(req_sum[c]));
            chk("soak_q_zero", 64'(q_of(c)), 64'd0);
        end
        chk("soak_v_idle", 64'(m_issue_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
